uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the serial I/O subsystem: configurable data width, parity and stop bits, with per-word error flags.
Received words are buffered in an internal FIFO and drained over a valid/ready handshake.
Adds false-start rejection, framing/parity checking and overrun reporting.
Sits between the board rxd pin and any byte-stream consumer.

Parameters:
CLK_DIV, 234, clk cycles per bit; legal range >=8
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB received first
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; 1 or 2
FIFO_DEPTH, 4, FIFO entries; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rxd  in  1  asynchronous serial input, idle high
m_data  out  DATA_BITS  head-of-FIFO data
m_frame_err  out  1  head word had a low stop bit
m_parity_err  out  1  head word failed parity; always 0 when PARITY=0
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts head word when m_valid & m_ready
overrun  out  1  sticky: a completed frame was dropped because the FIFO was full
clr_overrun  in  1  synchronous clear of overrun
busy  out  1  receiver not in IDLE

Behaviour:
- Reset values: m_data=0, m_frame_err=0, m_parity_err=0, m_valid=0, overrun=0, busy=0, FIFO empty, FSM in IDLE, synchroniser flops=1.
- Synchroniser: 2 flops on rxd; rxs = second flop. All logic uses rxs only. Latency from rxd to rxs is 2 cycles.
- Bit counter: 0..CLK_DIV-1. Each time it reaches its sample point, a one-cycle `tick` fires.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
- IDLE:
  - On rxs=0: load counter so the first tick fires CLK_DIV/2 cycles later (integer division); go to START.
- START, on tick:
  - rxs=1: false start, go to IDLE; nothing is pushed.
  - rxs=0: go to DATA; subsequent ticks fire every CLK_DIV cycles.
- DATA:
  - Sample rxs on each tick; shift right into a DATA_BITS shift register (first bit ends in bit 0).
  - After DATA_BITS samples: go to PAR if PARITY!=0, else STOP.
- PAR, on tick:
  - Compute parity_err: odd mode requires XOR(data, pbit)=1; even mode requires XOR(data, pbit)=0.
- STOP, on tick (repeated STOP_BITS times):
  - frame_err is set if any sampled stop bit is 0.
  - On the final stop tick, push {parity_err, frame_err, data} to the FIFO.
  - Then go to IDLE if rxs=1, else WAIT_HI.
- WAIT_HI: stay until rxs=1, then go to IDLE. No new start is detected while rxs stays low.
- Push timing: the pushed word appears at the FIFO output with m_valid=1 on the cycle after the final stop tick (FIFO previously empty).
- FIFO:
  - Pop occurs when m_valid & m_ready.
  - m_data and the error flags are valid whenever m_valid=1; otherwise they hold their last value.
- Push into a full FIFO:
  - Word is discarded; overrun=1 from the next cycle.
  - A simultaneous pop in the same cycle frees a slot, so the push succeeds and overrun is not set.
- overrun clears on clr_overrun. If clr_overrun and a new overrun event occur in the same cycle, set wins.
- busy=1 in every state except IDLE.
- Asynchronous reset mid-frame: discard the partial frame, empty the FIFO, and clear all flags immediately.

Optional Feature:
- Macro UART_RX_BREAK_DETECT_EN adds output `brk` (1 bit, reset 0).
- With the macro defined:
  - A frame whose data bits are all 0 and whose stop bit is 0 is a break.
  - A break is not pushed to the FIFO.
  - `brk` pulses high for 1 cycle at the final stop tick; the FSM then enters WAIT_HI.
- Without it: no `brk` port; the same frame is pushed with m_frame_err=1 and data=0.

Test Plan:
- CLK_DIV=16, 8N1: send 0xA5 -> after the stop bit, m_valid=1, m_data=0xA5, both error flags 0; pop with m_ready=1 -> m_valid=0.
- PARITY=2, 8E1: send 0x03 with parity bit 1 -> m_parity_err=1. Resend with parity bit 0 -> m_parity_err=0.
- Stop bit driven 0 on 0x5A, rxd held low 20 bit-times -> one word with m_frame_err=1; FSM stays in WAIT_HI (busy=1) until rxd returns high; no extra words.
  - With UART_RX_BREAK_DETECT_EN and data 0x00, same stimulus -> brk pulse, FIFO empty.
- rxd low glitch of 4 cycles (CLK_DIV=16) -> START rejects it, returns to IDLE; m_valid stays 0.
- FIFO_DEPTH=4, m_ready=0, send 5 bytes 0x01..0x05 -> overrun=1; drain yields 0x01..0x04; clr_overrun -> overrun=0.
- Assert rst in the middle of the DATA state of a frame -> all outputs return to reset values the same cycle; next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (2-flop sync, false-start reject, parity/framing check)
// feeding a FIFO drained over m_valid/m_ready; sticky overrun flag.
// Ports: clk, rst (async, active-high), rxd; m_data, m_frame_err,
//   m_parity_err, m_valid, m_ready; overrun, clr_overrun; busy.
// Optional: define UART_RX_BREAK_DETECT_EN to add the brk output.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  input  logic                 clr_overrun,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 brk,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HI
  } state_t;

  state_t               state;
  logic                 s1, s2, rxs;
  logic [CW-1:0]        cnt;
  logic [3:0]           nb;
  logic                 sc;
  logic [DATA_BITS-1:0] sh;
  logic                 fe, pe;
  logic                 tick, last_stop, fe_now;
  logic                 is_brk, push_req;
  logic [WW-1:0]        push_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
    end
  end
  assign rxs = s2;

  assign busy = (state != IDLE);
  assign tick = (state != IDLE) && (state != WAIT_HI) && (cnt == '0);
  assign last_stop = (STOP_BITS == 1) || sc;
  // Include the stop bit being sampled right now.
  assign fe_now = fe | ~rxs;
`ifdef UART_RX_BREAK_DETECT_EN
  assign is_brk = (sh == '0) && fe_now;
`else
  assign is_brk = 1'b0;
`endif
  assign push_req = (state == STOP) && tick && last_stop && !is_brk;
  assign push_word = {pe, fe_now, sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      nb    <= '0;
      sc    <= 1'b0;
      sh    <= '0;
      fe    <= 1'b0;
      pe    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk   <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_DETECT_EN
      brk <= 1'b0;
`endif
      if (tick) cnt <= CW'(CLK_DIV - 1);
      else if (cnt != '0) cnt <= cnt - 1'b1;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= CW'(CLK_DIV / 2 - 1);
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              nb    <= '0;
              sc    <= 1'b0;
              fe    <= 1'b0;
              pe    <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sh <= {rxs, sh[DATA_BITS-1:1]};
            if (nb == 4'(DATA_BITS - 1))
              state <= (PARITY != 0) ? PAR : STOP;
            else
              nb <= nb + 1'b1;
          end
        end
        PAR: begin
          if (tick) begin
            pe    <= (PARITY == 1) ? ~(^sh ^ rxs) : (^sh ^ rxs);
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            fe <= fe_now;
            if (last_stop) begin
`ifdef UART_RX_BREAK_DETECT_EN
              brk <= is_brk;
`endif
              state <= (rxs && !is_brk) ? IDLE : WAIT_HI;
            end else begin
              sc <= 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp, rp_n;
  logic [AW:0]   fcnt, left;
  logic [WW-1:0] head;
  logic          do_pop, do_push, full, ovf;

  assign do_pop  = m_valid & m_ready;
  assign full    = (fcnt == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push_req & (~full | do_pop);
  assign ovf     = push_req & full & ~do_pop;
  assign left    = fcnt - (AW+1)'(do_pop);
  assign rp_n    = rp + AW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_word;
  end

  // Head register holds its value when the FIFO drains empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      fcnt    <= '0;
      m_valid <= 1'b0;
      head    <= '0;
      overrun <= 1'b0;
    end else begin
      wp      <= wp + AW'(do_push);
      rp      <= rp_n;
      fcnt    <= left + (AW+1)'(do_push);
      m_valid <= (left + (AW+1)'(do_push)) != '0;
      if (left != '0) head <= mem[rp_n];
      else if (do_push) head <= push_word;
      if (ovf) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign {m_parity_err, m_frame_err, m_data} = head;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 and 8E1 instances, CLK_DIV=16.
// Covers rx, parity, framing/WAIT_HI, glitch, overrun, async reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_n = 1'b1, rxd_e = 1'b1;
  logic       rdy_n = 1'b0, rdy_e = 1'b0;
  logic       clr_n = 1'b0, clr_e = 1'b0;
  logic [7:0] dat_n, dat_e;
  logic       fe_n, fe_e, pe_n, pe_e;
  logic       val_n, val_e, ovr_n, ovr_e, bsy_n, bsy_e;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       brk_n, brk_e;
  int         brk_cnt = 0;
  always @(posedge clk) if (brk_n) brk_cnt <= brk_cnt + 1;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
    .clk(clk), .rst(rst), .rxd(rxd_n),
    .m_data(dat_n), .m_frame_err(fe_n), .m_parity_err(pe_n),
    .m_valid(val_n), .m_ready(rdy_n),
    .overrun(ovr_n), .clr_overrun(clr_n),
`ifdef UART_RX_BREAK_DETECT_EN
    .brk(brk_n),
`endif
    .busy(bsy_n));

  uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst(rst), .rxd(rxd_e),
    .m_data(dat_e), .m_frame_err(fe_e), .m_parity_err(pe_e),
    .m_valid(val_e), .m_ready(rdy_e),
    .overrun(ovr_e), .clr_overrun(clr_e),
`ifdef UART_RX_BREAK_DETECT_EN
    .brk(brk_e),
`endif
    .busy(bsy_e));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_n(input logic b);
    rxd_n = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic bit_e(input logic b);
    rxd_e = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_n(input logic [7:0] d, input logic sb);
    bit_n(1'b0);
    for (int i = 0; i < 8; i++) bit_n(d[i]);
    bit_n(sb);
  endtask

  task automatic send_e(input logic [7:0] d, input logic p);
    bit_e(1'b0);
    for (int i = 0; i < 8; i++) bit_e(d[i]);
    bit_e(p);
    bit_e(1'b1);
  endtask

  task automatic pop_n();
    rdy_n = 1'b1;
    @(negedge clk);
    rdy_n = 1'b0;
  endtask

  task automatic pop_e();
    rdy_e = 1'b1;
    @(negedge clk);
    rdy_e = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(val_n), 32'd0);
    chk("rst_data", 32'(dat_n), 32'd0);
    chk("rst_flags", {30'd0, fe_n, pe_n}, 32'd0);
    chk("rst_ovr", 32'(ovr_n), 32'd0);
    chk("rst_busy", 32'(bsy_n), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_n(8'hA5, 1'b1);
    chk("a5_valid", 32'(val_n), 32'd1);
    chk("a5_data", 32'(dat_n), 32'hA5);
    chk("a5_flags", {30'd0, fe_n, pe_n}, 32'd0);
    pop_n();
    chk("a5_popped", 32'(val_n), 32'd0);

    send_e(8'h03, 1'b1);
    chk("e_valid", 32'(val_e), 32'd1);
    chk("e_data", 32'(dat_e), 32'h03);
    chk("e_pe_bad", 32'(pe_e), 32'd1);
    pop_e();
    send_e(8'h03, 1'b0);
    chk("e_pe_ok", 32'(pe_e), 32'd0);
    chk("e_fe_ok", 32'(fe_e), 32'd0);
    pop_e();
    chk("e_empty", 32'(val_e), 32'd0);

    send_n(8'h5A, 1'b0);
    repeat (320) @(negedge clk);
    chk("fe_busy_low", 32'(bsy_n), 32'd1);
    chk("fe_valid", 32'(val_n), 32'd1);
    chk("fe_data", 32'(dat_n), 32'h5A);
    chk("fe_flag", 32'(fe_n), 32'd1);
    rxd_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("fe_idle", 32'(bsy_n), 32'd0);
    repeat (40) @(negedge clk);
    pop_n();
    chk("fe_one_word", 32'(val_n), 32'd0);

`ifdef UART_RX_BREAK_DETECT_EN
    send_n(8'h00, 1'b0);
    repeat (320) @(negedge clk);
    rxd_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("brk_pulse", 32'(brk_cnt), 32'd1);
    chk("brk_empty", 32'(val_n), 32'd0);
`else
    send_n(8'h00, 1'b0);
    repeat (320) @(negedge clk);
    rxd_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("z_valid", 32'(val_n), 32'd1);
    chk("z_data", 32'(dat_n), 32'd0);
    chk("z_fe", 32'(fe_n), 32'd1);
    pop_n();
`endif

    rxd_n = 1'b0;
    repeat (4) @(negedge clk);
    rxd_n = 1'b1;
    chk("gl_busy", 32'(bsy_n), 32'd1);
    repeat (30) @(negedge clk);
    chk("gl_idle", 32'(bsy_n), 32'd0);
    chk("gl_valid", 32'(val_n), 32'd0);

    for (int i = 1; i <= 4; i++) send_n(8'(i), 1'b1);
    chk("ov_not_yet", 32'(ovr_n), 32'd0);
    send_n(8'h05, 1'b1);
    chk("ov_set", 32'(ovr_n), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ov_drain", 32'(dat_n), 32'(i));
      pop_n();
    end
    chk("ov_empty", 32'(val_n), 32'd0);
    chk("ov_sticky", 32'(ovr_n), 32'd1);
    clr_n = 1'b1;
    @(negedge clk);
    clr_n = 1'b0;
    chk("ov_clr", 32'(ovr_n), 32'd0);

    send_n(8'h77, 1'b1);
    chk("rs_pre_valid", 32'(val_n), 32'd1);
    bit_n(1'b0);
    bit_n(1'b0);
    bit_n(1'b0);
    bit_n(1'b1);
    chk("rs_pre_busy", 32'(bsy_n), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_busy", 32'(bsy_n), 32'd0);
    chk("rs_valid", 32'(val_n), 32'd0);
    chk("rs_data", 32'(dat_n), 32'd0);
    rxd_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_n(8'h3C, 1'b1);
    chk("rs_rx_valid", 32'(val_n), 32'd1);
    chk("rs_rx_data", 32'(dat_n), 32'h3C);
    chk("rs_rx_fe", 32'(fe_n), 32'd0);
    pop_n();
    chk("rs_rx_empty", 32'(val_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
